debounce_pulser: RTL
====================

Name: debounce_pulser

Overview:
- Multi-channel debouncer and edge pulser for push-button and switch inputs.
- Per channel: a 2-flop synchroniser, a press/release FSM with a programmable noise-filter time, one-cycle press and release pulses, and a debounced level.
- Optional auto-repeat: a held button emits repeated press pulses (for digit-increment style UI).
- Sits between raw board inputs and the game-control FSMs; replaces per-button single-channel edge detectors.

Parameters:
- N_CH, 4, number of independent input channels.
- DEBOUNCE_CYC, 150000, minimum cycles a level must persist before a release is accepted or the next press is armed.
- REPEAT_DELAY, 25000000, cycles from the initial press pulse to the first repeat pulse.
- REPEAT_RATE, 5000000, cycles between successive repeat pulses.
- CNT_W, $clog2(max(DEBOUNCE_CYC,REPEAT_DELAY,REPEAT_RATE)+1), width of the per-channel counters; derived, not overridden.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- btn_in  in  N_CH  raw asynchronous inputs; active high.
- repeat_en  in  N_CH  per-channel auto-repeat enable; sampled every cycle.
- level  out  N_CH  debounced level.
- press_pulse  out  N_CH  one-cycle pulse on an accepted press and on each repeat.
- release_pulse  out  N_CH  one-cycle pulse on an accepted release.

Behaviour:
- Reset (synchronous, active-high):
  - sync flops, level, press_pulse and release_pulse all = 0.
  - FSM = IDLE, counters = 0.
  - Reset asserted mid-operation overrides everything in the same edge: no pulse is emitted in the reset cycle or the cycle after.
- Synchroniser: s = btn_in delayed by 2 flops. All FSM decisions use s only.
- All outputs are registered. Pulses are exactly 1 cycle wide.
- Per-channel FSM:
  - IDLE:
    - s=1 → HELD; press_pulse=1; level=1; hold_cnt=0; rep_cnt=0.
  - HELD:
    - hold_cnt increments each cycle and saturates at DEBOUNCE_CYC.
    - s=0 and hold_cnt==DEBOUNCE_CYC → REL; release_pulse=1; level=0; rel_cnt=0.
    - s=0 before saturation → ignored (bounce); stay in HELD, hold_cnt keeps counting.
    - Auto-repeat, while repeat_en=1 and s=1:
      - rep_cnt increments each cycle.
      - First repeat: press_pulse=1 when rep_cnt reaches REPEAT_DELAY-1 (i.e. REPEAT_DELAY cycles after the initial pulse); rep_cnt then reloads to 0.
      - Later repeats: every REPEAT_RATE cycles.
    - repeat_en=0 or s=0 → rep_cnt held at 0 and the first-repeat flag cleared, so re-enabling restarts with REPEAT_DELAY.
  - REL:
    - s=0 → rel_cnt increments.
    - s=1 → rel_cnt=0 (bounce restarts the filter).
    - rel_cnt==DEBOUNCE_CYC-1 with s=0 → IDLE.
    - A press is never accepted from REL.
- Latency: btn_in first sampled high at edge k → press_pulse high for the cycle following edge k+2.
- release_pulse: high for the cycle after the HELD→REL transition edge.
- press_pulse and release_pulse are never high together on one channel.
- Channels are fully independent. Simultaneous presses on several channels produce simultaneous pulses.
- Illegal FSM encoding → IDLE with outputs 0.
- Counters never wrap: hold_cnt saturates; rel_cnt and rep_cnt are cleared on every state change.

Decomposition:
- Package debounce_pkg:
  - state enum {IDLE, HELD, REL}, 2-bit.
  - function clog2-of-max used to derive CNT_W.
- Sub-module debounce_channel:
  - Holds the sync flops, FSM and counters for one channel; parameters DEBOUNCE_CYC, REPEAT_DELAY, REPEAT_RATE.
  - Top instantiates N_CH copies in a generate loop and only concatenates their outputs.

Test Plan (bench overrides: N_CH=2, DEBOUNCE_CYC=8, REPEAT_DELAY=20, REPEAT_RATE=5):
- Clean press: ch0 btn_in held high 40 cycles, repeat_en=0 → exactly one press_pulse 3 edges after the rise; level=1. On drop, release_pulse appears 3 edges later; level=0.
- Bouncy press: btn_in toggles 1,0,1,0,1 at 1-cycle spacing, then stays high → one press_pulse only; no release_pulse.
- Release bounce: after release, btn_in pulses high for 3 cycles within 8 cycles → no new press_pulse. A press 12 clean-low cycles after release → press_pulse accepted.
- Auto-repeat: repeat_en=1, btn_in held 40 cycles → press_pulses at relative cycles 0, 20, 25, 30, 35; single release_pulse at the end.
- Reset mid-hold: assert reset for 1 cycle while in HELD with btn_in still high → all outputs 0 at the next edge. After reset, still-high input yields a fresh press_pulse 3 edges after reset deasserts.
- Independence: ch0 and ch1 pressed on the same cycle, with ch1 released early → simultaneous press_pulses; ch1 release_pulse unaffected by ch0 state.

Source files
------------

// File: rtl/debounce_pkg.sv
// debounce_pulser shared types.
// FSM state encoding and counter width helper.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    REL  = 2'd2
  } state_t;

  function automatic int clog2_max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: 2-flop synchroniser,
// press/release FSM, noise filter and auto-repeat.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 150000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_in,
  input  logic repeat_en,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CNT_W =
    clog2_max3(DEBOUNCE_CYC, REPEAT_DELAY, REPEAT_RATE);

  localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] DB_END = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] RD_END = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RR_END = CNT_W'(REPEAT_RATE - 1);

  logic [1:0]       sync;
  logic             s;
  state_t           state;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] rel_cnt;
  logic [CNT_W-1:0] rep_cnt;
  logic             rep_armed;
  logic [CNT_W-1:0] rep_end;

  assign s = sync[1];

  // First repeat waits the long delay, later ones the short rate.
  assign rep_end = rep_armed ? RR_END : RD_END;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync          <= '0;
      state         <= IDLE;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      hold_cnt      <= '0;
      rel_cnt       <= '0;
      rep_cnt       <= '0;
      rep_armed     <= 1'b0;
    end else begin
      sync          <= {sync[0], btn_in};
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      unique case (state)
        IDLE: begin
          if (s) begin
            state       <= HELD;
            level       <= 1'b1;
            press_pulse <= 1'b1;
            hold_cnt    <= '0;
            rep_cnt     <= '0;
            rep_armed   <= 1'b0;
          end
        end
        HELD: begin
          if (hold_cnt != DB_MAX)
            hold_cnt <= hold_cnt + 1'b1;
          if (!s && hold_cnt == DB_MAX) begin
            state         <= REL;
            level         <= 1'b0;
            release_pulse <= 1'b1;
            hold_cnt      <= '0;
            rel_cnt       <= '0;
            rep_cnt       <= '0;
            rep_armed     <= 1'b0;
          end else if (s && repeat_en) begin
            if (rep_cnt == rep_end) begin
              press_pulse <= 1'b1;
              rep_cnt     <= '0;
              rep_armed   <= 1'b1;
            end else begin
              rep_cnt <= rep_cnt + 1'b1;
            end
          end else begin
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
          end
        end
        REL: begin
          if (s)
            rel_cnt <= '0;
          else if (rel_cnt == DB_END) begin
            state   <= IDLE;
            rel_cnt <= '0;
          end else
            rel_cnt <= rel_cnt + 1'b1;
        end
        default: begin
          state     <= IDLE;
          level     <= 1'b0;
          hold_cnt  <= '0;
          rel_cnt   <= '0;
          rep_cnt   <= '0;
          rep_armed <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/debounce_pulser.sv
// Multi-channel debouncer and edge pulser.
// Replicates debounce_channel and concatenates outputs.
module debounce_pulser
  import debounce_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int DEBOUNCE_CYC = 150000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N_CH-1:0] btn_in,
  input  logic [N_CH-1:0] repeat_en,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
    ) u_ch (
      .clock         (clock),
      .reset         (reset),
      .btn_in        (btn_in[i]),
      .repeat_en     (repeat_en[i]),
      .level         (level[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i])
    );
  end

endmodule
